// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI mode-0 target: register map, status bit
// positions and the frame FSM states.
package spi_target_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_BUSY     = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spiState_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes one asynchronous SPI pin into the clk domain and flags its
// rising and falling edges as single-cycle pulses.
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], pin_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign level_o = chain_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with a peripheral-bus register interface: one TX holding
// byte, one RX byte, all SPI pins sampled in the system clock domain.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        sclk_i,
    input  logic        ss_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        irq_o
);

    logic sclkLevel, sclkRise, sclkFall;
    logic ssLevel, ssRise, ssFall;
    logic [SYNC_STAGES-1:0] mosiChain_q;
    logic mosiSync;

    spiState_e  state_q, state_d;
    logic [7:0] txHold_q, txHold_d;
    logic       txEmpty_q, txEmpty_d;
    logic [7:0] txShift_q, txShift_d;
    logic [6:0] rxShift_q, rxShift_d;
    logic [7:0] rxData_q, rxData_d;
    logic       rxValid_q, rxValid_d;
    logic       overrun_q, overrun_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic       ready_q, ready_d;

    logic        busRead, busWrite;
    logic [1:0]  regSel;
    logic [7:0]  nextTx;
    logic [31:0] statusWord;
    logic [31:0] readMux;
    logic        unusedBits;

    // ss_n idles high so the target comes out of reset deselected and not busy
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclkSync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .pin_i   (sclk_i),
        .level_o (sclkLevel),
        .rise_o  (sclkRise),
        .fall_o  (sclkFall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssSync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .pin_i   (ss_n_i),
        .level_o (ssLevel),
        .rise_o  (ssRise),
        .fall_o  (ssFall)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mosiChain_q <= '0;
        end else begin
            mosiChain_q <= {mosiChain_q[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign mosiSync   = mosiChain_q[SYNC_STAGES-1];
    assign regSel     = addr_i[3:2];
    assign busRead    = valid_i & ready_q & ~(|wstrb_i);
    assign busWrite   = valid_i & ready_q & (|wstrb_i);
    assign nextTx     = txEmpty_q ? FILL_BYTE : txHold_q;
    assign statusWord = {28'b0, ~ssLevel, overrun_q, txEmpty_q, rxValid_q};
    assign unusedBits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:8]};

    always_comb begin
        readMux = '0;
        case (regSel)
            REG_DATA:   readMux = {24'b0, rxData_q};
            REG_STATUS: readMux = statusWord;
            default:    readMux = '0;
        endcase
    end

    // Ordering matters: bus clears come first so a same-cycle byte completion
    // or overrun wins, and the TX write comes last so it lands after a reload.
    always_comb begin
        state_d   = state_q;
        txHold_d  = txHold_q;
        txEmpty_d = txEmpty_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        rxData_d  = rxData_q;
        rxValid_d = rxValid_q;
        overrun_d = overrun_q;
        bitCnt_d  = bitCnt_q;
        ready_d   = valid_i & ~ready_q;

        if (busRead && regSel == REG_DATA) begin
            rxValid_d = 1'b0;
        end
        if (busWrite && regSel == REG_STATUS && wdata_i[STAT_OVERRUN]) begin
            overrun_d = 1'b0;
        end

        if (ssRise) begin
            state_d  = ST_IDLE;
            bitCnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ssFall) begin
                        txShift_d = nextTx;
                        txEmpty_d = 1'b1;
                        bitCnt_d  = 3'd0;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclkRise) begin
                        rxShift_d = {rxShift_q[5:0], mosiSync};
                        bitCnt_d  = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            if (!rxValid_q || (busRead && regSel == REG_DATA)) begin
                                rxData_d  = {rxShift_q, mosiSync};
                                rxValid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end else if (sclkFall) begin
                        if (bitCnt_q == 3'd0) begin
                            txShift_d = nextTx;
                            txEmpty_d = 1'b1;
                        end else begin
                            txShift_d = {txShift_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (busWrite && regSel == REG_DATA) begin
            txHold_d  = wdata_i[7:0];
            txEmpty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            txHold_q  <= 8'h00;
            txEmpty_q <= 1'b1;
            txShift_q <= 8'h00;
            rxShift_q <= 7'h00;
            rxData_q  <= 8'h00;
            rxValid_q <= 1'b0;
            overrun_q <= 1'b0;
            bitCnt_q  <= 3'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            txHold_q  <= txHold_d;
            txEmpty_q <= txEmpty_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            rxData_q  <= rxData_d;
            rxValid_q <= rxValid_d;
            overrun_q <= overrun_d;
            bitCnt_q  <= bitCnt_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = ready_q ? readMux : 32'h0;
    assign miso_o  = (state_q == ST_SHIFT) ? txShift_q[7] : 1'b0;
    assign irq_o   = rxValid_q | overrun_q;

endmodule
